// File: rtl/opf_pkg.sv
// Shared types and constants for the operand-fetch stage.
// Defines XLEN (default 32) when no build option overrides it.
// Optional feature: OPF_WB_BYPASS_EN enables write-back to operand bypass.
`ifndef XLEN
`define XLEN 32
`endif

package opf_pkg;

    localparam int unsigned XLEN_W    = `XLEN;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned OPF_TAG_W = 8;

    // Contents of the single-entry issue buffer.
    typedef struct packed {
        logic [XLEN_W-1:0]    rs1data;
        logic [XLEN_W-1:0]    rs2data;
        logic [REG_IDX_W-1:0] rdidx;
        logic                 rden;
        logic [OPF_TAG_W-1:0] tag;
    } opf_issue_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } opf_buf_state_t;

    // A register reference that can create a dependency (enabled, not x0).
    function automatic logic idx_live(input logic en, input logic [REG_IDX_W-1:0] idx);
        return en & (idx != '0);
    endfunction

endpackage

// File: rtl/igpr_access_interface.sv
// GPR read-port interface: two asynchronous read ports.
// master drives rs1index/rs2index and receives rs1data/rs2data.
`ifndef XLEN
`define XLEN 32
`endif

interface igpr_access_interface;
    logic [4:0]         rs1index;
    logic [4:0]         rs2index;
    logic [`XLEN-1:0]   rs1data;
    logic [`XLEN-1:0]   rs2data;

    modport master (output rs1index, output rs2index, input rs1data, input rs2data);
    modport slave  (input rs1index, input rs2index, output rs1data, output rs2data);
endinterface

// File: rtl/gpr_operand_fetch_sb.sv
// gpr_scoreboard: per-register busy bits for outstanding writers.
// Ports: clk_i/arst_i, flush_i (clear all), set_en_i/set_idx_i (new writer),
//        clr_en_i/clr_idx_i (write-back), rs1/rs2/rd lookup indices and
//        combinational busy lookups *_busy_c.
module gpr_scoreboard
    import opf_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 flush_i,
    input  logic                 set_en_i,
    input  logic [REG_IDX_W-1:0] set_idx_i,
    input  logic                 clr_en_i,
    input  logic [REG_IDX_W-1:0] clr_idx_i,
    input  logic [REG_IDX_W-1:0] rs1idx_i,
    input  logic [REG_IDX_W-1:0] rs2idx_i,
    input  logic [REG_IDX_W-1:0] rdidx_i,
    output logic                 rs1_busy_c,
    output logic                 rs2_busy_c,
    output logic                 rd_busy_c
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clear before set so a same-cycle set of the same index wins; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
        if (flush_i) busy_d = '0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy_c = busy_q[rs1idx_i];
    assign rs2_busy_c = busy_q[rs2idx_i];
    assign rd_busy_c  = busy_q[rdidx_i];

endmodule

// File: rtl/gpr_operand_fetch.sv
// gpr_operand_fetch: decode -> execute operand fetch/issue stage.
// Accepts one decoded instruction per handshake, reads rs1/rs2 through the
// gpr master port, stalls on RAW/WAW hazards against a busy scoreboard and
// holds the result in a one-entry issue buffer.
// Ports: clk_i, arst_i (async, active-high), flush_i, dec_* (decode side),
//        gpr (igpr_access_interface.master), wb_* (write-back), iss_* (execute).
// Build option: OPF_WB_BYPASS_EN forwards same-cycle write-back data to operands.
module gpr_operand_fetch
    import opf_pkg::*;
#(
    parameter int unsigned TAG_W = 8,
    parameter int unsigned NREG  = 32
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 flush_i,
    input  logic                 dec_valid_i,
    output logic                 dec_ready_o,
    input  logic                 dec_rs1en_i,
    input  logic                 dec_rs2en_i,
    input  logic [REG_IDX_W-1:0] dec_rs1idx_i,
    input  logic [REG_IDX_W-1:0] dec_rs2idx_i,
    input  logic                 dec_rden_i,
    input  logic [REG_IDX_W-1:0] dec_rdidx_i,
    input  logic [TAG_W-1:0]     dec_tag_i,
    igpr_access_interface.master gpr,
    input  logic                 wb_valid_i,
    input  logic [REG_IDX_W-1:0] wb_rdidx_i,
    input  logic [`XLEN-1:0]     wb_data_i,
    output logic                 iss_valid_o,
    input  logic                 iss_ready_i,
    output logic [`XLEN-1:0]     iss_rs1data_o,
    output logic [`XLEN-1:0]     iss_rs2data_o,
    output logic                 iss_rden_o,
    output logic [REG_IDX_W-1:0] iss_rdidx_o,
    output logic [TAG_W-1:0]     iss_tag_o
);

    opf_buf_state_t state_q, state_d;
    opf_issue_t     iss_q, iss_d;

    logic rs1_busy, rs2_busy, rd_busy;
    logic byp1, byp2;
    logic hz1, hz2, hzw;
    logic free, accept;
    logic [XLEN_W-1:0] op1, op2;

    assign gpr.rs1index = dec_rs1idx_i;
    assign gpr.rs2index = dec_rs2idx_i;

`ifdef OPF_WB_BYPASS_EN
    assign byp1 = wb_valid_i & (wb_rdidx_i == dec_rs1idx_i) & (dec_rs1idx_i != '0);
    assign byp2 = wb_valid_i & (wb_rdidx_i == dec_rs2idx_i) & (dec_rs2idx_i != '0);
`else
    // Without bypass the consumer waits for the GPR file write on the wb edge.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data_i;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    gpr_scoreboard #(.NREG(NREG)) u_sb (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .flush_i    (flush_i),
        .set_en_i   (accept & dec_rden_i & (dec_rdidx_i != '0)),
        .set_idx_i  (dec_rdidx_i),
        .clr_en_i   (wb_valid_i & (wb_rdidx_i != '0)),
        .clr_idx_i  (wb_rdidx_i),
        .rs1idx_i   (dec_rs1idx_i),
        .rs2idx_i   (dec_rs2idx_i),
        .rdidx_i    (dec_rdidx_i),
        .rs1_busy_c (rs1_busy),
        .rs2_busy_c (rs2_busy),
        .rd_busy_c  (rd_busy)
    );

    assign hz1 = idx_live(dec_rs1en_i, dec_rs1idx_i) & rs1_busy & ~byp1;
    assign hz2 = idx_live(dec_rs2en_i, dec_rs2idx_i) & rs2_busy & ~byp2;
    assign hzw = idx_live(dec_rden_i, dec_rdidx_i) & rd_busy;

    // Buffer may drain and refill in the same cycle.
    assign free        = ~iss_valid_o | iss_ready_i;
    assign dec_ready_o = free & ~flush_i & ~(dec_valid_i & (hz1 | hz2 | hzw));
    assign accept      = dec_valid_i & dec_ready_o;

    // Operand select: x0 / unused -> 0, then bypass, then register file.
    always_comb begin
        op1 = gpr.rs1data;
        op2 = gpr.rs2data;
        if (byp1) op1 = wb_data_i;
        if (byp2) op2 = wb_data_i;
        if (!idx_live(dec_rs1en_i, dec_rs1idx_i)) op1 = '0;
        if (!idx_live(dec_rs2en_i, dec_rs2idx_i)) op2 = '0;
    end

    // Issue buffer next state; flush overrides accept and drain.
    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        if (flush_i) begin
            state_d = BUF_EMPTY;
        end else if (accept) begin
            state_d       = BUF_FULL;
            iss_d.rs1data = op1;
            iss_d.rs2data = op2;
            iss_d.rdidx   = dec_rdidx_i;
            iss_d.rden    = dec_rden_i;
            iss_d.tag     = OPF_TAG_W'(dec_tag_i);
        end else if (iss_ready_i) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= BUF_EMPTY;
            iss_q   <= '0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
        end
    end

    assign iss_valid_o   = (state_q == BUF_FULL);
    assign iss_rs1data_o = iss_q.rs1data;
    assign iss_rs2data_o = iss_q.rs2data;
    assign iss_rden_o    = iss_q.rden;
    assign iss_rdidx_o   = iss_q.rdidx;
    // Tag is stored at the package width and resized to the port width.
    assign iss_tag_o     = TAG_W'(iss_q.tag);

endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Directed bench for gpr_operand_fetch with a behavioural GPR file.
module tb_gpr_operand_fetch;
    import opf_pkg::*;

    localparam int unsigned TAG_W = 8;

    logic                 clk_i;
    logic                 arst_i;
    logic                 flush_i;
    logic                 dec_valid_i;
    logic                 dec_ready_o;
    logic                 dec_rs1en_i;
    logic                 dec_rs2en_i;
    logic [4:0]           dec_rs1idx_i;
    logic [4:0]           dec_rs2idx_i;
    logic                 dec_rden_i;
    logic [4:0]           dec_rdidx_i;
    logic [TAG_W-1:0]     dec_tag_i;
    logic                 wb_valid_i;
    logic [4:0]           wb_rdidx_i;
    logic [XLEN_W-1:0]    wb_data_i;
    logic                 iss_valid_o;
    logic                 iss_ready_i;
    logic [XLEN_W-1:0]    iss_rs1data_o;
    logic [XLEN_W-1:0]    iss_rs2data_o;
    logic                 iss_rden_o;
    logic [4:0]           iss_rdidx_o;
    logic [TAG_W-1:0]     iss_tag_o;

    int total = 0;
    int bad   = 0;

    igpr_access_interface gpr_if ();

    gpr_operand_fetch #(.TAG_W(TAG_W), .NREG(32)) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .flush_i       (flush_i),
        .dec_valid_i   (dec_valid_i),
        .dec_ready_o   (dec_ready_o),
        .dec_rs1en_i   (dec_rs1en_i),
        .dec_rs2en_i   (dec_rs2en_i),
        .dec_rs1idx_i  (dec_rs1idx_i),
        .dec_rs2idx_i  (dec_rs2idx_i),
        .dec_rden_i    (dec_rden_i),
        .dec_rdidx_i   (dec_rdidx_i),
        .dec_tag_i     (dec_tag_i),
        .gpr           (gpr_if),
        .wb_valid_i    (wb_valid_i),
        .wb_rdidx_i    (wb_rdidx_i),
        .wb_data_i     (wb_data_i),
        .iss_valid_o   (iss_valid_o),
        .iss_ready_i   (iss_ready_i),
        .iss_rs1data_o (iss_rs1data_o),
        .iss_rs2data_o (iss_rs2data_o),
        .iss_rden_o    (iss_rden_o),
        .iss_rdidx_o   (iss_rdidx_o),
        .iss_tag_o     (iss_tag_o)
    );

    // Register file: x0 holds garbage on purpose, x3=0x11, x4=0x22.
    logic [XLEN_W-1:0] gpr_mem [32];
    assign gpr_if.rs1data = gpr_mem[gpr_if.rs1index];
    assign gpr_if.rs2data = gpr_mem[gpr_if.rs2index];

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < 32; i++) gpr_mem[i] <= XLEN_W'(32'hDEAD_0000 + i);
            gpr_mem[3] <= XLEN_W'(32'h11);
            gpr_mem[4] <= XLEN_W'(32'h22);
        end else if (wb_valid_i && wb_rdidx_i != 5'd0) begin
            gpr_mem[wb_rdidx_i] <= wb_data_i;
        end
    end

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic r1e, input logic [4:0] r1,
                         input logic r2e, input logic [4:0] r2,
                         input logic rde, input logic [4:0] rd, input logic [7:0] tg);
        dec_valid_i  = v;
        dec_rs1en_i  = r1e;
        dec_rs1idx_i = r1;
        dec_rs2en_i  = r2e;
        dec_rs2idx_i = r2;
        dec_rden_i   = rde;
        dec_rdidx_i  = rd;
        dec_tag_i    = tg;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid_i = v;
        wb_rdidx_i = rd;
        wb_data_i  = XLEN_W'(d);
    endtask

    initial begin
        arst_i      = 1'b0;
        flush_i     = 1'b0;
        iss_ready_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        wb(1'b0, 5'd0, 32'h0);
        #1 arst_i = 1'b1;
        #10;
        // Reset state
        chk("rst_valid", 32'(iss_valid_o), 32'h0);
        chk("rst_rs1", 32'(iss_rs1data_o), 32'h0);
        chk("rst_rs2", 32'(iss_rs2data_o), 32'h0);
        chk("rst_rd", 32'(iss_rdidx_o), 32'h0);
        chk("rst_rden", 32'(iss_rden_o), 32'h0);
        chk("rst_tag", 32'(iss_tag_o), 32'h0);
        chk("rst_busy", 32'(dut.u_sb.busy_q), 32'h0);
        chk("rst_ready", 32'(dec_ready_o), 32'h1);
        arst_i = 1'b0;
        tick();

        // First issue: rs1=x3, rs2=x4, rd=x5
        drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 8'hA1);
        #1 chk("s1_ready", 32'(dec_ready_o), 32'h1);
        tick();
        chk("s1_valid", 32'(iss_valid_o), 32'h1);
        chk("s1_rs1", 32'(iss_rs1data_o), 32'h11);
        chk("s1_rs2", 32'(iss_rs2data_o), 32'h22);
        chk("s1_rd", 32'(iss_rdidx_o), 32'h5);
        chk("s1_tag", 32'(iss_tag_o), 32'hA1);
        chk("s1_busy", 32'(dut.u_sb.busy_q), 32'h20);

        // RAW on x5 while backpressured: stall, outputs stable
        drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 8'hB2);
        #1 chk("raw_bp_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("raw_bp_valid", 32'(iss_valid_o), 32'h1);
        chk("raw_bp_rs1", 32'(iss_rs1data_o), 32'h11);
        chk("raw_bp_tag", 32'(iss_tag_o), 32'hA1);

        // Drain; RAW still blocks the refill
        iss_ready_i = 1'b1;
        #1 chk("raw_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("raw_drain_valid", 32'(iss_valid_o), 32'h0);

        // Write-back x5 = 0xAB
        wb(1'b1, 5'd5, 32'hAB);
`ifdef OPF_WB_BYPASS_EN
        #1 chk("byp_ready", 32'(dec_ready_o), 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
`else
        #1 chk("wb_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("wb_valid", 32'(iss_valid_o), 32'h0);
        chk("wb_busy", 32'(dut.u_sb.busy_q), 32'h0);
        wb(1'b0, 5'd0, 32'h0);
        #1 chk("post_wb_ready", 32'(dec_ready_o), 32'h1);
        tick();
`endif
        chk("raw_iss_valid", 32'(iss_valid_o), 32'h1);
        chk("raw_iss_rs1", 32'(iss_rs1data_o), 32'hAB);
        chk("raw_iss_rs2", 32'(iss_rs2data_o), 32'h0);
        chk("raw_iss_tag", 32'(iss_tag_o), 32'hB2);
        chk("raw_busy", 32'(dut.u_sb.busy_q), 32'h40);

        // WAW: first writer of x7
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 8'hC3);
        #1 chk("waw_a_ready", 32'(dec_ready_o), 32'h1);
        tick();
        chk("waw_a_tag", 32'(iss_tag_o), 32'hC3);
        chk("waw_a_busy", 32'(dut.u_sb.busy_q), 32'hC0);

        // Second writer of x7 stalls
        drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd7, 8'hD4);
        #1 chk("waw_b_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("waw_b_valid", 32'(iss_valid_o), 32'h0);
        chk("waw_b_busy", 32'(dut.u_sb.busy_q), 32'hC0);

        // Write-back x7 still stalls the WAW this cycle
        wb(1'b1, 5'd7, 32'h77);
        #1 chk("waw_wb_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("waw_wb_busy", 32'(dut.u_sb.busy_q), 32'h40);

        // Accept with a same-cycle clear of x7: set wins
        wb(1'b1, 5'd7, 32'h99);
        #1 chk("waw_acc_ready", 32'(dec_ready_o), 32'h1);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("waw_acc_valid", 32'(iss_valid_o), 32'h1);
        chk("waw_acc_tag", 32'(iss_tag_o), 32'hD4);
        chk("waw_acc_rs1", 32'(iss_rs1data_o), 32'h11);
        chk("waw_acc_busy", 32'(dut.u_sb.busy_q), 32'hC0);

        // x0 operands and rd: zeros, no stall, scoreboard untouched, no bubble
        drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 8'hE5);
        #1 chk("x0_ready", 32'(dec_ready_o), 32'h1);
        tick();
        chk("x0_valid", 32'(iss_valid_o), 32'h1);
        chk("x0_rs1", 32'(iss_rs1data_o), 32'h0);
        chk("x0_rs2", 32'(iss_rs2data_o), 32'h0);
        chk("x0_tag", 32'(iss_tag_o), 32'hE5);
        chk("x0_busy", 32'(dut.u_sb.busy_q), 32'hC0);

        // Disabled rs1 gives 0 even for a live register
        drive(1'b1, 1'b0, 5'd3, 1'b1, 5'd4, 1'b0, 5'd9, 8'hF6);
        #1 chk("en_ready", 32'(dec_ready_o), 32'h1);
        tick();
        chk("en_rs1", 32'(iss_rs1data_o), 32'h0);
        chk("en_rs2", 32'(iss_rs2data_o), 32'h22);
        chk("en_rden", 32'(iss_rden_o), 32'h0);
        chk("en_busy", 32'(dut.u_sb.busy_q), 32'hC0);

        // Make x5 busy again
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 8'h11);
        tick();
        chk("fl_setup_busy", 32'(dut.u_sb.busy_q), 32'hE0);

        // Pure backpressure
        iss_ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 8'h33);
        #1 chk("bp_ready", 32'(dec_ready_o), 32'h0);
        tick();
        chk("bp_tag", 32'(iss_tag_o), 32'h11);
        chk("bp_valid", 32'(iss_valid_o), 32'h1);

        // Stalled instruction, then flush while FULL
        drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd8, 8'h22);
        flush_i = 1'b1;
        #1 chk("fl_ready", 32'(dec_ready_o), 32'h0);
        tick();
        flush_i = 1'b0;
        chk("fl_valid", 32'(iss_valid_o), 32'h0);
        chk("fl_busy", 32'(dut.u_sb.busy_q), 32'h0);
        #1 chk("post_fl_ready", 32'(dec_ready_o), 32'h1);
        tick();
        chk("post_fl_valid", 32'(iss_valid_o), 32'h1);
        chk("post_fl_tag", 32'(iss_tag_o), 32'h22);
        chk("post_fl_rs1", 32'(iss_rs1data_o), 32'hAB);
        chk("post_fl_busy", 32'(dut.u_sb.busy_q), 32'h100);

        // Asynchronous reset mid-operation
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 8'h00);
        #2 arst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(iss_valid_o), 32'h0);
        chk("arst_tag", 32'(iss_tag_o), 32'h0);
        chk("arst_busy", 32'(dut.u_sb.busy_q), 32'h0);
        chk("arst_ready", 32'(dec_ready_o), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
